round_sequencer: RTL

ROUND_SEQUENCER -- requirements
Module: round_sequencer

---
 rtl/round_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// round_sequencer: match-level controller for a guessing game.
// Runs a best-of-ROUNDS match: arms the guess FSM once per round, forwards
// the speed tick while a round is in play, scores win/lose pulses, holds the
// result for HOLD_TICKS slow ticks and then starts the next round or ends the match.
// Optional feature macro: ROUND_TIMEOUT_EN. When defined, a round with no
// win/lose after TIMEOUT_TICKS tick_slow pulses is scored as a loss.
module round_sequencer #(
  parameter int ROUNDS        = 5,
  parameter int STREAK        = 2,
  parameter int HOLD_TICKS    = 3,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick_slow,
  input  logic       tick_fast,
  input  logic       win,
  input  logic       lose,
  output logic       game_rst,
  output logic       game_en,
  output logic [3:0] score_p,
  output logic [3:0] score_c,
  output logic [3:0] round,
  output logic       level,
  output logic       match_over,
  output logic       player_won
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_RESULT,
    S_DONE
  } state_t;

  localparam logic [3:0] ROUNDS_L  = 4'(ROUNDS);
  localparam logic [3:0] MAJORITY  = 4'((ROUNDS + 1) / 2);
  localparam logic [3:0] STREAK_L  = 4'(STREAK);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] score_p_q, score_p_d;
  logic [3:0] score_c_q, score_c_d;
  logic [3:0] round_q, round_d;
  logic [3:0] streak_q, streak_d;
  logic [3:0] streak_inc;
  logic       level_q, level_d;
  logic [7:0] hold_q, hold_d;
  logic       lose_ev;

`ifdef ROUND_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);
  logic [7:0] to_q, to_d;
  logic       timeout_hit;

  // A round times out on the slow tick that completes TIMEOUT_TICKS pulses.
  assign timeout_hit = tick_slow && (to_q == TIMEOUT_LAST);
  assign lose_ev     = lose || timeout_hit;
`else
  assign lose_ev = lose;
`endif

  // Saturating streak increment so a long run of wins never wraps to zero.
  assign streak_inc = (streak_q != 4'hF) ? streak_q + 4'd1 : streak_q;

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d   = state_q;
    score_p_d = score_p_q;
    score_c_d = score_c_q;
    round_d   = round_q;
    streak_d  = streak_q;
    level_d   = level_q;
    hold_d    = hold_q;
`ifdef ROUND_TIMEOUT_EN
    to_d      = to_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        // A new match clears all bookkeeping and begins at round 1.
        if (start) begin
          state_d   = S_ARM;
          score_p_d = 4'd0;
          score_c_d = 4'd0;
          round_d   = 4'd1;
          streak_d  = 4'd0;
          level_d   = 1'b0;
        end
      end
      S_ARM: begin
        state_d = S_PLAY;
`ifdef ROUND_TIMEOUT_EN
        to_d    = 8'd0;
`endif
      end
      S_PLAY: begin
        // A simultaneous win and lose resolves in the player's favour.
        if (win) begin
          if (score_p_q < ROUNDS_L) score_p_d = score_p_q + 4'd1;
          streak_d = streak_inc;
          if (streak_inc >= STREAK_L) level_d = 1'b1;
          hold_d   = 8'd0;
          state_d  = S_RESULT;
        end else if (lose_ev) begin
          if (score_c_q < ROUNDS_L) score_c_d = score_c_q + 4'd1;
          streak_d = 4'd0;
          hold_d   = 8'd0;
          state_d  = S_RESULT;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (tick_slow) begin
          to_d = to_q + 8'd1;
        end
`endif
      end
      S_RESULT: begin
        // Hold the result on screen, then decide whether the match is settled.
        if (tick_slow) begin
          if (hold_q == HOLD_LAST) begin
            if (score_p_q >= MAJORITY || score_c_q >= MAJORITY || round_q >= ROUNDS_L) begin
              state_d = S_DONE;
            end else begin
              round_d = round_q + 4'd1;
              state_d = S_ARM;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      score_p_q <= 4'd0;
      score_c_q <= 4'd0;
      round_q   <= 4'd0;
      streak_q  <= 4'd0;
      level_q   <= 1'b0;
      hold_q    <= 8'd0;
`ifdef ROUND_TIMEOUT_EN
      to_q      <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      score_p_q <= score_p_d;
      score_c_q <= score_c_d;
      round_q   <= round_d;
      streak_q  <= streak_d;
      level_q   <= level_d;
      hold_q    <= hold_d;
`ifdef ROUND_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  // Outputs decode straight from state; game_en passes the selected tick through.
  always_comb begin
    game_rst   = (state_q == S_ARM);
    game_en    = 1'b0;
    if (state_q == S_PLAY) game_en = level_q ? tick_fast : tick_slow;
    score_p    = score_p_q;
    score_c    = score_c_q;
    round      = round_q;
    level      = level_q;
    match_over = (state_q == S_DONE);
    player_won = (state_q == S_DONE) && (score_p_q > score_c_q);
  end

endmodule
